// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state codes, SPI mode constants and edge-counter sizing
package spi_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t SETUP = 3'd2;
    localparam state_t SHIFT = 3'd3;
    localparam state_t HOLD  = 3'd4;
    localparam state_t GAP   = 3'd5;
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;
    function automatic int edge_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous TX FIFO of {dc, data} words with full/empty flags
module spi_tx_fifo #(
    parameter int W = 9,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    logic do_push, do_pop;
    assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign empty = wr == rd;
    assign rdata = mem[rd[AW-1:0]];
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: FIFO-fed SPI master with all CPOL/CPHA modes, SS hold and D/C side bit
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W = 8,
    localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_en,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [SS_W-1:0]   i_ss_sel,
    input  logic              i_ss_hold,
    input  logic              i_irq_en,
    input  logic              i_irq_clr,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_dc,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_busy,
    output logic              o_irq,
    output logic              o_spi_sck,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso,
    output logic [NUM_SS-1:0] o_spi_ss_n,
    output logic              o_spi_dc
);
    localparam int EW = edge_w(DATA_W);
    state_t state, nxt;
    logic full, empty, f_dc, pop, edge_tick, to_hold, to_gap, tick, last, sample, drive;
    logic cpol_l, cpha_l, lsb_l, lsb, out_bit;
    logic [1:0] mode;
    logic [DATA_W-1:0] f_data, tx_sh, rx_sh, tx_src, tx_shifted, rx_shift, rx_nx;
    logic [DIV_W-1:0] cnt, div_l;
    logic [EW-1:0] ecnt, edge_num;
    logic [NUM_SS-1:0] ss_dec;

    spi_tx_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(i_sysclk),
        .rst(i_sysrst),
        .push(i_tx_valid && o_tx_ready),
        .pop(pop),
        .wdata({i_tx_dc, i_tx_data}),
        .rdata({f_dc, f_data}),
        .full(full),
        .empty(empty)
    );

    assign o_tx_ready = !full;
    assign mode = {cpol_l, cpha_l};
    assign tick = cnt == div_l;
    assign edge_num = (state == SETUP) ? EW'(1) : ecnt + EW'(1);
    assign last = edge_num == EW'(2 * DATA_W);
    assign sample = edge_tick && (edge_num[0] ? mode inside {MODE0, MODE2} : mode inside {MODE1, MODE3});
    assign drive = edge_tick && !last && (edge_num[0] ? mode inside {MODE1, MODE3} : mode inside {MODE0, MODE2});
    // The LOAD cycle shifts straight from the FIFO head with the incoming bit order
    assign tx_src = pop ? f_data : tx_sh;
    assign lsb = pop ? i_lsb_first : lsb_l;
    assign out_bit = lsb ? tx_src[0] : tx_src[DATA_W-1];
    assign tx_shifted = lsb ? tx_src >> 1 : tx_src << 1;
    assign rx_shift = lsb_l ? {i_spi_miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], i_spi_miso};
    assign rx_nx = sample ? rx_shift : rx_sh;

    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) if (i_ss_sel == SS_W'(i)) ss_dec[i] = 1'b0;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (!empty && i_en) ? LOAD : IDLE;
            LOAD:    nxt = SETUP;
            SETUP:   nxt = tick ? SHIFT : SETUP;
            SHIFT:   nxt = (tick && last) ? HOLD : SHIFT;
            HOLD:    nxt = tick ? ((i_ss_hold && !empty && i_en) ? LOAD : GAP) : HOLD;
            GAP:     nxt = tick ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = state == LOAD;
        edge_tick = (state == SETUP || state == SHIFT) && tick;
        to_hold = state == SHIFT && nxt == HOLD;
        to_gap = state == HOLD && nxt == GAP;
        o_busy = state != IDLE || !empty;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            cnt <= '0;
            div_l <= '0;
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
            lsb_l <= 1'b0;
            ecnt <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
            o_rx_data <= '0;
            o_rx_valid <= 1'b0;
            o_irq <= 1'b0;
            o_spi_sck <= 1'b0;
            o_spi_mosi <= 1'b0;
            o_spi_ss_n <= '1;
            o_spi_dc <= 1'b0;
        end else begin
            cnt <= (pop || tick) ? '0 : cnt + 1'b1;
            o_rx_valid <= to_hold;
            o_irq <= (to_gap && empty && i_irq_en) || (o_irq && !i_irq_clr);
            rx_sh <= rx_nx;
            if (to_hold) o_rx_data <= rx_nx;
            if (to_gap) o_spi_ss_n <= '1;
            if (edge_tick) begin
                o_spi_sck <= !o_spi_sck;
                ecnt <= edge_num;
            end
            if (drive) begin
                o_spi_mosi <= out_bit;
                tx_sh <= tx_shifted;
            end
            if (pop) begin
                div_l <= i_div;
                cpol_l <= i_cpol;
                cpha_l <= i_cpha;
                lsb_l <= i_lsb_first;
                o_spi_dc <= f_dc;
                o_spi_sck <= i_cpol;
                o_spi_ss_n <= ss_dec;
                ecnt <= '0;
                rx_sh <= '0;
                tx_sh <= i_cpha ? f_data : tx_shifted;
                o_spi_mosi <= i_cpha ? o_spi_mosi : out_bit;
            end
        end
    end
endmodule
